serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the single-bit subtract helper.
package serial_subtractor_pkg;

    // Encoding is fixed so sibling serial blocks can share it.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic bout;
        logic d;
    } sub_bit_t;

    function automatic sub_bit_t sub_bit(input logic a, input logic b, input logic bin);
        sub_bit_t r;
        r.d    = a ^ b ^ bin;
        r.bout = (~a & b) | (~(a ^ b) & bin);
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    sub_bit_t res;

    always_comb begin
        res  = sub_bit(a, b, bin);
        d    = res.d;
        bout = res.bout;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Operands are captured on an accepted start; results appear with a one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             bin;
    logic [CntW-1:0]  cnt;
    logic             last_bit;
    logic             d_bit;
    logic             bout_bit;

    assign last_bit = (cnt == CntW'(WIDTH - 1));

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (start) state_next = StRun;
            StRun:   if (last_bit) state_next = StDone;
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (state != StIdle);
        done = (state == StDone);
    end

    // Shift registers, borrow, counter and the dedicated result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        sd  <= '0;
                        bin <= 1'b0;
                        cnt <= '0;
                    end
                end
                StRun: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= {d_bit, sd[WIDTH-1:1]};
                    bin <= bout_bit;
                    if (last_bit) begin
                        diff   <= {d_bit, sd[WIDTH-1:1]};
                        borrow <= bout_bit;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts one operation from IDLE and checks latency, busy and results.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb);
        int n;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        n = 1;
        check("busy_c1", 32'(busy), 32'd1);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd9);
        check("busy_done", 32'(busy), 32'd1);
        check("diff", 32'(diff), 32'(ed));
        check("borrow", 32'(borrow), 32'(eb));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("diff_hold", 32'(diff), 32'(ed));
    endtask

    initial begin
        int n_done;
        int t_done[$];
        logic [7:0] ra, rb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        do_op(8'h05, 8'h03, 8'h02, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1);
        do_op(8'h00, 8'hFF, 8'h01, 1'b1);
        do_op(8'hFF, 8'h01, 8'hFE, 1'b0);
        do_op(8'h00, 8'h00, 8'h00, 1'b0);

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                a = 8'h10; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) n_done++;
            @(negedge clk);
        end
        check("ign_ndone", 32'(n_done), 32'd1);
        check("ign_diff", 32'(diff), 32'h02);
        check("ign_borrow", 32'(borrow), 32'd0);

        // Make outputs nonzero, then abort mid-RUN with reset.
        do_op(8'h03, 8'h05, 8'hFE, 1'b1);
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_nodone", 32'(n_done), 32'd0);
        do_op(8'h80, 8'h7F, 8'h01, 1'b0);

        // Held start: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 30) start = 1'b0;
            if (done) begin
                t_done.push_back(i);
                check("hold_diff", 32'(diff), 32'h22);
                check("hold_borrow", 32'(borrow), 32'd0);
            end
        end
        check("hold_count", 32'(t_done.size()), 32'd3);
        if (t_done.size() == 3) begin
            check("hold_t0", 32'(t_done[0]), 32'd9);
            check("hold_t1", 32'(t_done[1]), 32'd19);
            check("hold_t2", 32'(t_done[2]), 32'd29);
        end
        repeat (2) @(negedge clk);
        check("hold_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, 8'(ra - rb), (ra < rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
